// File: rtl/spmv_pkg.sv
// Shared constants and FSM encoding for the CSR sparse matrix-vector row scheduler,
// its SRAM read ports and the MAC core.
package spmv_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned RIDX_W      = 8;
    localparam int unsigned DEF_ROWS    = 16;
    localparam int unsigned DEF_AW      = 8;
    localparam int unsigned DEF_RP_BASE = 0;
    localparam int unsigned DEF_CI_BASE = 32;
    localparam int unsigned DEF_IV_BASE = 0;
    localparam int unsigned DEF_MV_BASE = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RP0   = 3'd1,
        S_ROW   = 3'd2,
        S_NZ    = 3'd3,
        S_IV    = 3'd4,
        S_EMIT  = 3'd5,
        S_RDONE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/spmv_sram_rd_port.sv
// One-cycle-latency SRAM read port: strobe/address drive plus a capture register.
// o_data shows the bus word in the capture cycle and the held word afterwards.
module spmv_sram_rd_port
    import spmv_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              o_rd_en,
    output logic [AW-1:0]     o_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [DATA_W-1:0] o_data
);

    logic              pend_q, pend_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        pend_d = i_req;
        data_d = pend_q ? i_sram_data : data_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign o_rd_en = i_req;
    assign o_addr  = i_req ? i_addr : '0;
    assign o_data  = data_d;

endmodule

// File: rtl/spmv_row_scheduler.sv
// CSR row scheduler: walks row_ptr/col_idx/values in SRAM and hands (A[r][c], x[c])
// pairs to the MAC core with valid/ready, flagging rows and end of matrix.
//
// state   | meaning
// IDLE    | wait for i_start
// RP0     | read row_ptr[0] into k (ph0 strobe, ph1 capture)
// ROW     | read row_ptr[r+1] into kend, clamp a decreasing pointer to an empty row
// NZ      | read col_idx[k] and value[k] together
// IV      | read x[col]
// EMIT    | present pair until accepted
// RDONE   | row complete pulse, advance r
// DONE    | end-of-matrix pulse
module spmv_row_scheduler
    import spmv_pkg::*;
#(
    parameter int unsigned ROWS    = DEF_ROWS,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned RP_BASE = DEF_RP_BASE,
    parameter int unsigned CI_BASE = DEF_CI_BASE,
    parameter int unsigned IV_BASE = DEF_IV_BASE,
    parameter int unsigned MV_BASE = DEF_MV_BASE
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en_A,
    output logic [AW-1:0]     o_addr_A,
    input  logic [DATA_W-1:0] i_read_data_A,
    output logic              o_rd_en_B,
    output logic [AW-1:0]     o_addr_B,
    input  logic [DATA_W-1:0] i_read_data_B,
    output logic              o_pair_valid,
    input  logic              i_pair_ready,
    output logic [DATA_W-1:0] o_mat_val,
    output logic [DATA_W-1:0] o_vec_val,
    output logic              o_row_done,
    output logic [RIDX_W-1:0] o_row_idx,
    output logic              o_err
);

    state_t            state_q, state_d;
    logic              ph_q, ph_d;
    logic [DATA_W-1:0] k_q, k_d, kend_q, kend_d, col_q, col_d;
    logic [DATA_W-1:0] mat_q, mat_d, vec_q, vec_d;
    logic [RIDX_W-1:0] r_q, r_d;
    logic              err_q, err_d;

    logic              rd_req_a, rd_req_b;
    logic [AW-1:0]     rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [DATA_W-1:0] row_end, k_inc;
    logic              ptr_back, last_row;

    // A row_ptr that goes backwards is treated as an empty row ending at k.
    assign ptr_back = rdata_b < k_q;
    assign row_end  = ptr_back ? k_q : rdata_b;
    assign k_inc    = k_q + 16'd1;
    assign last_row = r_q == RIDX_W'(ROWS - 1);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = 1'b0;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RP0;
            S_RP0: begin
                ph_d = !ph_q;
                if (ph_q) state_d = S_ROW;
            end
            S_ROW: begin
                ph_d = !ph_q;
                if (ph_q) state_d = (k_q < row_end) ? S_NZ : S_RDONE;
            end
            S_NZ: begin
                ph_d = !ph_q;
                if (ph_q) state_d = S_IV;
            end
            S_IV: begin
                ph_d = !ph_q;
                if (ph_q) state_d = S_EMIT;
            end
            S_EMIT:  if (i_pair_ready) state_d = (k_inc < kend_q) ? S_NZ : S_RDONE;
            S_RDONE: state_d = last_row ? S_DONE : S_ROW;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = state_q != S_IDLE;
        o_done       = state_q == S_DONE;
        o_row_done   = state_q == S_RDONE;
        o_pair_valid = state_q == S_EMIT;
        rd_req_a     = 1'b0;
        rd_req_b     = 1'b0;
        rd_addr_a    = '0;
        rd_addr_b    = '0;
        case (state_q)
            S_RP0: if (!ph_q) begin
                rd_req_b  = 1'b1;
                rd_addr_b = AW'(RP_BASE);
            end
            S_ROW: if (!ph_q) begin
                rd_req_b  = 1'b1;
                rd_addr_b = AW'(RP_BASE) + AW'(r_q) + AW'(1);
            end
            S_NZ: if (!ph_q) begin
                rd_req_b  = 1'b1;
                rd_addr_b = AW'(CI_BASE) + AW'(k_q);
                rd_req_a  = 1'b1;
                rd_addr_a = AW'(MV_BASE) + AW'(k_q);
            end
            S_IV: if (!ph_q) begin
                rd_req_a  = 1'b1;
                rd_addr_a = AW'(IV_BASE) + AW'(col_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        k_d    = k_q;
        kend_d = kend_q;
        col_d  = col_q;
        mat_d  = mat_q;
        vec_d  = vec_q;
        r_d    = r_q;
        err_d  = err_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                err_d = 1'b0;
                r_d   = '0;
            end
            S_RP0: if (ph_q) k_d = rdata_b;
            S_ROW: if (ph_q) begin
                kend_d = row_end;
                if (ptr_back) err_d = 1'b1;
            end
            S_NZ: if (ph_q) begin
                col_d = rdata_b;
                mat_d = rdata_a;
            end
            S_IV:   if (ph_q) vec_d = rdata_a;
            S_EMIT: if (i_pair_ready) k_d = k_inc;
            S_RDONE: begin
                k_d = kend_q;
                if (!last_row) r_d = r_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            k_q    <= '0;
            kend_q <= '0;
            col_q  <= '0;
            mat_q  <= '0;
            vec_q  <= '0;
            r_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            k_q    <= k_d;
            kend_q <= kend_d;
            col_q  <= col_d;
            mat_q  <= mat_d;
            vec_q  <= vec_d;
            r_q    <= r_d;
            err_q  <= err_d;
        end
    end

    spmv_sram_rd_port #(.AW(AW)) u_port_a (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req       (rd_req_a),
        .i_addr      (rd_addr_a),
        .o_rd_en     (o_rd_en_A),
        .o_addr      (o_addr_A),
        .i_sram_data (i_read_data_A),
        .o_data      (rdata_a)
    );

    spmv_sram_rd_port #(.AW(AW)) u_port_b (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req       (rd_req_b),
        .i_addr      (rd_addr_b),
        .o_rd_en     (o_rd_en_B),
        .o_addr      (o_addr_B),
        .i_sram_data (i_read_data_B),
        .o_data      (rdata_b)
    );

    assign o_mat_val = mat_q;
    assign o_vec_val = vec_q;
    assign o_row_idx = r_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_spmv_row_scheduler.sv
// Directed bench for spmv_row_scheduler with ROWS=2 and behavioural SRAM models.
module tb_spmv_row_scheduler;

    logic        i_clk;
    logic        i_rstn;
    logic        i_start;
    logic        i_pair_ready;
    logic [15:0] i_read_data_A, i_read_data_B;
    logic        o_busy, o_done, o_rd_en_A, o_rd_en_B, o_pair_valid, o_row_done, o_err;
    logic [7:0]  o_addr_A, o_addr_B, o_row_idx;
    logic [15:0] o_mat_val, o_vec_val;

    spmv_row_scheduler #(.ROWS(2)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_rd_en_A     (o_rd_en_A),
        .o_addr_A      (o_addr_A),
        .i_read_data_A (i_read_data_A),
        .o_rd_en_B     (o_rd_en_B),
        .o_addr_B      (o_addr_B),
        .i_read_data_B (i_read_data_B),
        .o_pair_valid  (o_pair_valid),
        .i_pair_ready  (i_pair_ready),
        .o_mat_val     (o_mat_val),
        .o_vec_val     (o_vec_val),
        .o_row_done    (o_row_done),
        .o_row_idx     (o_row_idx),
        .o_err         (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    always @(posedge i_clk) begin
        if (o_rd_en_A) i_read_data_A <= mem0[o_addr_A];
        if (o_rd_en_B) i_read_data_B <= mem1[o_addr_B];
    end

    typedef struct {
        logic [2:0][15:0] rp;
        logic [4:0][15:0] col;
        logic [4:0][15:0] mv;
        logic [1:0][15:0] x;
        logic [2:0][15:0] exp_mat;
        logic [2:0][15:0] exp_vec;
        int               npairs;
        int               row0_pairs;
        logic             exp_err;
        int               done_cyc;
    } vec_t;

    vec_t vecs [4];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk(name, {o_busy, o_done, o_rd_en_A, o_rd_en_B, o_addr_A, o_addr_B, o_pair_valid,
                   o_mat_val, o_vec_val, o_row_done, o_row_idx, o_err}, 64'd0);
    endtask

    task automatic run_vec(input int vi, input int stall, input bit abort);
        vec_t v;
        int   np, rows_seen, held, extra;
        bit   got_done;
        v = vecs[vi];
        for (int a = 0; a < 256; a++) begin
            mem0[a] = 16'hB000 + 16'(a);
            mem1[a] = 16'hC000 + 16'(a);
        end
        for (int i = 0; i < 3; i++) mem1[i] = v.rp[i];
        for (int i = 0; i < 5; i++) begin
            mem1[32+i] = v.col[i];
            mem0[32+i] = v.mv[i];
        end
        mem0[0] = v.x[0];
        mem0[1] = v.x[1];
        i_pair_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        np = 0; rows_seen = 0; held = 0; got_done = 1'b0; extra = 0;
        for (int cyc = 1; cyc <= 300 && !got_done; cyc++) begin
            if (o_pair_valid) begin
                chk("no_strobe_in_emit", {o_rd_en_A, o_rd_en_B}, 2'b00);
                chk("pair_in_range", np < v.npairs, 1'b1);
                if (np < v.npairs) begin
                    chk("mat_val", o_mat_val, v.exp_mat[np]);
                    chk("vec_val", o_vec_val, v.exp_vec[np]);
                end
                if (abort && rows_seen == 1) begin
                    i_start = 1'b0;
                    i_rstn  = 1'b0;
                    @(negedge i_clk);
                    check_zero("abort_zero");
                    i_rstn = 1'b1;
                    for (int i = 0; i < 15; i++) begin
                        @(negedge i_clk);
                        if (o_done || o_row_done || o_busy) extra++;
                    end
                    chk("abort_quiet", extra, 0);
                    return;
                end
                if (np == 0 && held < stall) begin
                    i_pair_ready = 1'b0;
                    held++;
                end else begin
                    i_pair_ready = 1'b1;
                    np++;
                end
            end else begin
                i_pair_ready = 1'b1;
            end
            if (o_row_done) begin
                chk("row_idx", o_row_idx, rows_seen);
                chk("row_done_pairs", np, (rows_seen == 0) ? v.row0_pairs : v.npairs);
                rows_seen++;
            end
            if (o_done) begin
                chk("done_cycle", cyc, v.done_cyc + stall);
                chk("err_flag", o_err, v.exp_err);
                chk("pair_count", np, v.npairs);
                chk("row_count", rows_seen, 2);
                got_done = 1'b1;
            end else begin
                chk("busy", o_busy, 1'b1);
            end
            i_start = (cyc == 10);
            if (!got_done) @(negedge i_clk);
        end
        if (!got_done) chk("done_timeout", 1'b0, 1'b1);
        i_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_done) extra++;
        end
        chk("single_done", extra, 0);
        chk("idle_after", o_busy, 1'b0);
        chk("err_sticky", o_err, v.exp_err);
    endtask

    initial begin
        // Packed arrays list the highest index first.
        vecs[0].rp = {16'd3, 16'd2, 16'd0};
        vecs[0].col = {16'd0, 16'd0, 16'd1, 16'd0, 16'd1};
        vecs[0].mv = {16'd0, 16'd0, 16'd7, 16'd6, 16'd5};
        vecs[0].x = {16'd20, 16'd10};
        vecs[0].exp_mat = {16'd7, 16'd6, 16'd5};
        vecs[0].exp_vec = {16'd20, 16'd10, 16'd20};
        vecs[0].npairs = 3; vecs[0].row0_pairs = 2; vecs[0].exp_err = 1'b0; vecs[0].done_cyc = 24;

        vecs[1].rp = {16'd2, 16'd0, 16'd0};
        vecs[1].col = {16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        vecs[1].mv = {16'd0, 16'd0, 16'd0, 16'd6, 16'd5};
        vecs[1].x = {16'd20, 16'd10};
        vecs[1].exp_mat = {16'd0, 16'd6, 16'd5};
        vecs[1].exp_vec = {16'd0, 16'd10, 16'd20};
        vecs[1].npairs = 2; vecs[1].row0_pairs = 0; vecs[1].exp_err = 1'b0; vecs[1].done_cyc = 19;

        vecs[2].rp = {16'd5, 16'd1, 16'd3};
        vecs[2].col = {16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
        vecs[2].mv = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5};
        vecs[2].x = {16'd20, 16'd10};
        vecs[2].exp_mat = {16'd0, 16'd9, 16'd8};
        vecs[2].exp_vec = {16'd0, 16'd20, 16'd10};
        vecs[2].npairs = 2; vecs[2].row0_pairs = 0; vecs[2].exp_err = 1'b1; vecs[2].done_cyc = 19;

        vecs[3].rp = {16'd4, 16'd3, 16'd1};
        vecs[3].col = {16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
        vecs[3].mv = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5};
        vecs[3].x = {16'd40, 16'd30};
        vecs[3].exp_mat = {16'd8, 16'd7, 16'd6};
        vecs[3].exp_vec = {16'd30, 16'd40, 16'd30};
        vecs[3].npairs = 3; vecs[3].row0_pairs = 2; vecs[3].exp_err = 1'b0; vecs[3].done_cyc = 24;

        i_rstn = 1'b0;
        i_start = 1'b0;
        i_pair_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        check_zero("reset_zero");
        i_rstn = 1'b1;
        repeat (2) @(negedge i_clk);
        check_zero("idle_zero");

        for (int vi = 0; vi < 4; vi++) run_vec(vi, 0, 1'b0);
        run_vec(0, 4, 1'b0);
        run_vec(0, 0, 1'b1);
        run_vec(0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
